// File: rtl/immgen_pipe.sv
// Registered RISC-V immediate generator with a valid/ready interface.
// Output register plus one skid entry sustains full throughput under backpressure.
module immgen_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned TAG_WIDTH = 32,
  parameter bit          EN_ZIMM   = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [31:0]          instr_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [XLEN-1:0]      imm_o,
  output logic [2:0]           fmt_o,
  output logic                 illegal_o,
  output logic [TAG_WIDTH-1:0] tag_o
);

  typedef enum logic [2:0] {
    FmtI = 3'b000,
    FmtS = 3'b001,
    FmtB = 3'b010,
    FmtJ = 3'b011,
    FmtU = 3'b100,
    FmtR = 3'b101,
    FmtZ = 3'b110,
    FmtX = 3'b111
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0]      imm;
    logic [2:0]           fmt;
    logic                 ill;
    logic [TAG_WIDTH-1:0] tag;
  } entry_t;

  fmt_e               dec_fmt;
  logic signed [31:0] imm32;
  entry_t             dec_entry;

  always_comb begin
    dec_fmt = FmtX;
    if (instr_i[1:0] == 2'b11) begin
      case (instr_i[6:2])
        5'b00000, 5'b00100, 5'b11001, 5'b00011: dec_fmt = FmtI;
        5'b00110: dec_fmt = (XLEN == 64) ? FmtI : FmtX;
        5'b01000: dec_fmt = FmtS;
        5'b11000: dec_fmt = FmtB;
        5'b11011: dec_fmt = FmtJ;
        5'b01101, 5'b00101: dec_fmt = FmtU;
        5'b01100: dec_fmt = FmtR;
        5'b01110: dec_fmt = (XLEN == 64) ? FmtR : FmtX;
        5'b11100: dec_fmt = (EN_ZIMM && instr_i[14]) ? FmtZ : FmtI;
        default:  dec_fmt = FmtX;
      endcase
    end
  end

  // Build the 32-bit immediate as signed so the XLEN cast sign-extends it.
  always_comb begin
    imm32 = '0;
    unique case (dec_fmt)
      FmtI: imm32 = {{21{instr_i[31]}}, instr_i[30:20]};
      FmtS: imm32 = {{21{instr_i[31]}}, instr_i[30:25], instr_i[11:7]};
      FmtB: imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FmtJ: imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      FmtU: imm32 = {instr_i[31:12], 12'b0};
      FmtZ: imm32 = {27'b0, instr_i[19:15]};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec_entry.imm = XLEN'(imm32);
    dec_entry.fmt = dec_fmt;
    dec_entry.ill = (dec_fmt == FmtX);
    dec_entry.tag = tag_i;
  end

  entry_t or_q, or_d, sk_q, sk_d;
  logic   or_valid_q, or_valid_d, sk_valid_q, sk_valid_d;
  logic   ready_q;
  logic   accept;

  assign accept = valid_i & ready_q;

  always_comb begin
    or_d       = or_q;
    sk_d       = sk_q;
    or_valid_d = or_valid_q;
    sk_valid_d = sk_valid_q;
    if (flush_i) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end else if (!or_valid_q || ready_i) begin
      // Output register is free this cycle; the skid entry always goes first.
      if (sk_valid_q) begin
        or_d       = sk_q;
        or_valid_d = 1'b1;
        sk_valid_d = 1'b0;
      end else begin
        or_valid_d = accept;
        if (accept) or_d = dec_entry;
      end
    end else if (accept) begin
      sk_d       = dec_entry;
      sk_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      or_q       <= '0;
      sk_q       <= '0;
      or_valid_q <= 1'b0;
      sk_valid_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      or_q       <= or_d;
      sk_q       <= sk_d;
      or_valid_q <= or_valid_d;
      sk_valid_q <= sk_valid_d;
      ready_q    <= ~sk_valid_d;
    end
  end

  assign ready_o   = ready_q;
  assign valid_o   = or_valid_q;
  assign imm_o     = or_q.imm;
  assign fmt_o     = or_q.fmt;
  assign illegal_o = or_q.ill;
  assign tag_o     = or_q.tag;

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: default build is scoreboard-checked; EN_ZIMM=0 and
// XLEN=64 builds share the same stimulus and are checked inline.
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid, ready_in;
  logic [31:0] instr, tag;

  logic        rdy_a, vo_a, ill_a;
  logic [31:0] imm_a, tag_a;
  logic [2:0]  fmt_a;
  logic        rdy_n, vo_n, ill_n;
  logic [31:0] imm_n, tag_n;
  logic [2:0]  fmt_n;
  logic        rdy_w, vo_w, ill_w;
  logic [63:0] imm_w;
  logic [31:0] tag_w;
  logic [2:0]  fmt_w;

  always #5 clk = ~clk;

  immgen_pipe #(.XLEN(32), .TAG_WIDTH(32), .EN_ZIMM(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(rdy_a),
    .instr_i(instr), .tag_i(tag), .valid_o(vo_a), .ready_i(ready_in), .imm_o(imm_a),
    .fmt_o(fmt_a), .illegal_o(ill_a), .tag_o(tag_a)
  );

  immgen_pipe #(.XLEN(32), .TAG_WIDTH(32), .EN_ZIMM(1'b0)) dut_nz (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(rdy_n),
    .instr_i(instr), .tag_i(tag), .valid_o(vo_n), .ready_i(ready_in), .imm_o(imm_n),
    .fmt_o(fmt_n), .illegal_o(ill_n), .tag_o(tag_n)
  );

  immgen_pipe #(.XLEN(64), .TAG_WIDTH(32), .EN_ZIMM(1'b1)) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .valid_i(valid), .ready_o(rdy_w),
    .instr_i(instr), .tag_i(tag), .valid_o(vo_w), .ready_i(ready_in), .imm_o(imm_w),
    .fmt_o(fmt_w), .illegal_o(ill_w), .tag_o(tag_w)
  );

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Inputs only change 1 time unit after posedge, so a handshake seen here
  // is the one that completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vo_a === 1'b1 && ready_in === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got tag=%h imm=%h, wanted no output", tag_a, imm_a);
      end else begin
        mon_e = sb.pop_front();
        if ({imm_a, fmt_a, ill_a, tag_a} !== {mon_e.imm, mon_e.fmt, mon_e.ill, mon_e.tag}) begin
          n_err++;
          $display("FAIL sb_entry: got imm=%h fmt=%b ill=%b tag=%h, wanted imm=%h fmt=%b ill=%b tag=%h",
                   imm_a, fmt_a, ill_a, tag_a, mon_e.imm, mon_e.fmt, mon_e.ill, mon_e.tag);
        end
      end
    end
  end

  task automatic expect_out(input logic [31:0] imm, input logic [2:0] fmt, input logic ill,
                            input logic [31:0] tg);
    exp_t e;
    e.imm = imm; e.fmt = fmt; e.ill = ill; e.tag = tg;
    sb.push_back(e);
  endtask

  task automatic put(input logic [31:0] ins, input logic [31:0] tg);
    @(posedge clk); #1;
    valid = 1'b1; instr = ins; tag = tg;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; valid = 1'b0; ready_in = 1'b0; instr = '0; tag = '0;
    #12;
    n_cmp += 6;
    if (vo_a !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b wanted 0", vo_a); end
    if (rdy_a !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b wanted 1", rdy_a); end
    if (imm_a !== 32'h0) begin n_err++; $display("FAIL rst_imm: got %h wanted 0", imm_a); end
    if (fmt_a !== 3'b000) begin n_err++; $display("FAIL rst_fmt: got %b wanted 000", fmt_a); end
    if (ill_a !== 1'b0) begin n_err++; $display("FAIL rst_ill: got %b wanted 0", ill_a); end
    if (tag_a !== 32'h0) begin n_err++; $display("FAIL rst_tag: got %h wanted 0", tag_a); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_addi();
    @(posedge clk); #1;
    ready_in = 1'b1;
    expect_out(32'hFFFF_FFFF, 3'b000, 1'b0, 32'h100);
    put(32'hFFF0_0093, 32'h100);
    @(negedge clk);
    n_cmp++;
    if (vo_a !== 1'b0) begin n_err++; $display("FAIL addi_early: valid_o got %b wanted 0", vo_a); end
    idle();
    @(negedge clk);
    n_cmp += 2;
    if (vo_a !== 1'b1) begin n_err++; $display("FAIL addi_latency: valid_o got %b wanted 1", vo_a); end
    if (imm_a !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL addi_imm: got %h wanted ffffffff", imm_a);
    end
  endtask

  task automatic test_back_to_back();
    expect_out(32'hFFFF_FFFC, 3'b010, 1'b0, 32'h200);
    expect_out(32'h1234_5000, 3'b100, 1'b0, 32'h204);
    put(32'hFE00_0EE3, 32'h200);
    put(32'h1234_50B7, 32'h204);
    @(negedge clk);
    n_cmp++;
    if (vo_a !== 1'b1 || fmt_a !== 3'b010) begin
      n_err++; $display("FAIL b2b_beq: got valid=%b fmt=%b wanted 1 010", vo_a, fmt_a);
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (vo_a !== 1'b1 || fmt_a !== 3'b100) begin
      n_err++; $display("FAIL b2b_lui: got valid=%b fmt=%b wanted 1 100", vo_a, fmt_a);
    end
    @(negedge clk);
    n_cmp++;
    if (vo_a !== 1'b0) begin n_err++; $display("FAIL b2b_drain: valid_o got %b wanted 0", vo_a); end
  endtask

  task automatic test_zimm();
    expect_out(32'h0000_001F, 3'b110, 1'b0, 32'h300);
    put(32'h300F_D073, 32'h300);
    idle();
    @(negedge clk);
    n_cmp++;
    if (vo_n !== 1'b1 || imm_n !== 32'h0000_0300 || fmt_n !== 3'b000) begin
      n_err++;
      $display("FAIL zimm_off: got valid=%b imm=%h fmt=%b wanted 1 00000300 000", vo_n, imm_n, fmt_n);
    end
  endtask

  task automatic test_xlen64();
    expect_out(32'hFFF0_0000, 3'b011, 1'b0, 32'h40);
    expect_out(32'h0000_0000, 3'b111, 1'b1, 32'h44);
    expect_out(32'h0000_0000, 3'b111, 1'b1, 32'h48);
    put(32'h8000_006F, 32'h40);
    put(32'h0000_0010, 32'h44);
    @(negedge clk);
    n_cmp++;
    if (imm_w !== 64'hFFFF_FFFF_FFF0_0000 || fmt_w !== 3'b011) begin
      n_err++; $display("FAIL x64_jal: got imm=%h fmt=%b wanted fffffffffff00000 011", imm_w, fmt_w);
    end
    put(32'hFFF0_009B, 32'h48);
    @(negedge clk);
    n_cmp++;
    if (imm_w !== 64'h0 || fmt_w !== 3'b111 || ill_w !== 1'b1) begin
      n_err++;
      $display("FAIL x64_illegal: got imm=%h fmt=%b ill=%b wanted 0 111 1", imm_w, fmt_w, ill_w);
    end
    idle();
    @(negedge clk);
    n_cmp++;
    if (imm_w !== 64'hFFFF_FFFF_FFFF_FFFF || fmt_w !== 3'b000 || ill_w !== 1'b0) begin
      n_err++;
      $display("FAIL x64_addiw: got imm=%h fmt=%b ill=%b wanted all-ones 000 0", imm_w, fmt_w, ill_w);
    end
  endtask

  task automatic test_backpressure();
    bit got_in = 1'b0;
    @(posedge clk); #1;
    ready_in = 1'b0;
    expect_out(32'h0000_0000, 3'b000, 1'b0, 32'h10);
    expect_out(32'h0000_0004, 3'b000, 1'b0, 32'h14);
    expect_out(32'h0000_0008, 3'b000, 1'b0, 32'h18);
    put(32'h0000_0013, 32'h10);
    put(32'h0040_0013, 32'h14);
    put(32'h0080_0013, 32'h18);
    @(negedge clk);
    n_cmp++;
    if (rdy_a !== 1'b0) begin n_err++; $display("FAIL bp_ready_drop: got %b wanted 0", rdy_a); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (vo_a !== 1'b1 || tag_a !== 32'h10 || imm_a !== 32'h0 || rdy_a !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold: got valid=%b tag=%h imm=%h ready=%b wanted 1 10 0 0",
                 vo_a, tag_a, imm_a, rdy_a);
      end
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rdy_a === 1'b1) begin got_in = 1'b1; break; end
    end
    idle();
    n_cmp++;
    if (!got_in) begin n_err++; $display("FAIL bp_reaccept: ready_o stayed 0, wanted 1"); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    ready_in = 1'b0;
    put(32'h0000_0013, 32'h30);
    put(32'h0000_0013, 32'h34);
    put(32'h0000_0013, 32'h38);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (vo_a !== 1'b0 || rdy_a !== 1'b1) begin
      n_err++; $display("FAIL flush_full: got valid=%b ready=%b wanted 0 1", vo_a, rdy_a);
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    put(32'h0000_0013, 32'h3C);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (vo_a !== 1'b0) begin n_err++; $display("FAIL flush_stale: valid_o got %b wanted 0", vo_a); end
    end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    ready_in = 1'b0;
    put(32'h0000_0013, 32'h50);
    put(32'h0000_0013, 32'h54);
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (vo_a !== 1'b0 || rdy_a !== 1'b1 || tag_a !== 32'h0) begin
      n_err++;
      $display("FAIL async_rst: got valid=%b ready=%b tag=%h wanted 0 1 0", vo_a, rdy_a, tag_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_zimm();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_async_reset();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++; $display("FAIL sb_drain: %0d entries outstanding, wanted 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Parametrised, registered successor to the combinational immediate generator. Sits at the decode-stage boundary.
- Accepts a raw 32-bit instruction plus a tag (normally the PC) over a valid/ready handshake.
- Produces the sign- or zero-extended XLEN immediate, a format code and an illegal flag one cycle later.
- A 2-entry skid buffer gives full throughput under downstream backpressure; flush_i supports branch-redirect squashing.

Parameters:
XLEN, 32, immediate/output width; legal values 32 or 64
TAG_WIDTH, 32, width of sideband tag carried alongside the instruction
EN_ZIMM, 1, 1 = decode CSR-immediate (zimm) format; 0 = treat all SYSTEM as I-type

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
flush_i  input  1  synchronous squash of all held entries
valid_i  input  1  upstream instruction valid
ready_o  output  1  block can accept an instruction
instr_i  input  32  raw instruction
tag_i  input  TAG_WIDTH  sideband tag (PC)
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
imm_o  output  XLEN  extended immediate
fmt_o  output  3  format: I=000 S=001 B=010 J=011 U=100 R=101 Z=110 X(illegal)=111
illegal_o  output  1  unrecognised opcode or instr_i[1:0] != 2'b11
tag_o  output  TAG_WIDTH  tag of result

Behaviour:
- Reset (rst_ni low, async): valid_o=0, imm_o=0, fmt_o=000, illegal_o=0, tag_o=0, skid empty, ready_o=1.
- Decode (combinational on instr_i, opcode=instr_i[6:2]):
  - I: 00000, 00100, 11001, 00011, 00110 (00110 only if XLEN=64; otherwise X).
  - S: 01000. B: 11000. J: 11011. U: 01101, 00101.
  - R: 01100; 01110 only if XLEN=64. R immediate is 0.
  - SYSTEM 11100: Z when EN_ZIMM=1 and instr_i[14]=1; otherwise I.
  - Anything else, or instr_i[1:0] != 11: fmt X, imm 0, illegal 1.
- Extension:
  - I/S/B/J: sign-extend from instr_i[31] to XLEN using the standard RISC-V bit scatter; B and J have bit0=0.
  - U: {instr_i[31:12], 12'b0}, sign-extended to XLEN.
  - Z: zero-extended instr_i[19:15].
- Handshake:
  - Transfer in on valid_i & ready_o; transfer out on valid_o & ready_i.
  - Latency is exactly 1 cycle, from accept to valid_o, when the output register is empty or draining.
- Storage: output register (OR) plus skid register (SK); ready_o = ~SK.valid, registered.
- States by occupancy:
  - EMPTY: OR invalid. Accept loads OR.
  - ONE: OR valid, SK empty.
    - ready_i=1 with accept: OR reloads (throughput 1/cycle).
    - ready_i=1, no accept: -> EMPTY.
    - ready_i=0 with accept: new entry goes to SK -> FULL.
  - FULL: ready_o=0.
    - ready_i=1: SK moves to OR -> ONE.
    - ready_i=0: hold.
- Outputs stay stable while valid_o=1 & ready_i=0. Ordering is strictly FIFO; no entry is dropped or duplicated.
- flush_i:
  - Next edge: OR and SK invalid, state EMPTY. A valid_i in the same cycle is discarded.
  - Data registers may keep stale values; only valid is cleared.
  - valid_o=1 during the flush cycle may still handshake that cycle.
- Reset asserted mid-operation clears everything immediately; deassertion is assumed to be synchronised externally.

Test Plan:
- addi 0xFFF00093, ready_i=1 -> next cycle valid_o=1, imm_o=0xFFFFFFFF, fmt_o=000, illegal_o=0.
- beq 0xFE000EE3 then lui 0x123450B7 back-to-back -> imm 0xFFFFFFFC fmt 010, then 0x12345000 fmt 100, on consecutive cycles.
- csrrwi 0x300FD073 with EN_ZIMM=1 -> imm 0x0000001F, fmt 110; with EN_ZIMM=0 -> imm 0x00000300, fmt 000.
- Hold ready_i=0 and present 3 instructions with tags 0x10, 0x14, 0x18:
  - ready_o drops after the 2nd is accepted.
  - After releasing ready_i, outputs are tags 0x10, 0x14, 0x18 in order with no loss.
- Fill FULL, then pulse flush_i with valid_i=1 -> next cycle valid_o=0, ready_o=1, and no stale output appears.
- XLEN=64: jal 0x8000006F -> imm 0xFFFFFFFFFFF00000, fmt 011; instr 0x00000013 with [1:0] forced to 00 -> fmt 111, illegal_o=1, imm 0.
